// File: rtl/writeback_merge_queue.sv
// rtl/writeback_merge_queue.sv - per-unit writeback FIFOs merged onto register-file write ports
module writeback_merge_queue #(
   parameter int NUM_UNITS       = 4,
   parameter int NUM_WB_PORTS    = 2,
   parameter int FIFO_DEPTH      = 4,
   parameter int REG_ADDR_WIDTH  = 5,
   parameter int DATA_WIDTH      = 64,
   parameter int UNIT_CODE_WIDTH = 3,
   localparam int CNT_WIDTH      = $clog2(FIFO_DEPTH + 1)
) (
   input  logic                                    clock_i,
   input  logic                                    reset_i,
   input  logic [NUM_UNITS-1:0]                    unitValid_i,
   output logic [NUM_UNITS-1:0]                    unitReady_o,
   input  logic [NUM_UNITS*REG_ADDR_WIDTH-1:0]     unitAddr_i,
   input  logic [NUM_UNITS*DATA_WIDTH-1:0]         unitData_i,
   input  logic [NUM_UNITS*UNIT_CODE_WIDTH-1:0]    unitCode_i,
   input  logic                                    stall_i,
   output logic [NUM_WB_PORTS-1:0]                 wbEnable_o,
   output logic [NUM_WB_PORTS*REG_ADDR_WIDTH-1:0]  wbAddr_o,
   output logic [NUM_WB_PORTS*DATA_WIDTH-1:0]      wbData_o,
   output logic [NUM_WB_PORTS*UNIT_CODE_WIDTH-1:0] wbCode_o,
   output logic [NUM_UNITS*CNT_WIDTH-1:0]          fifoCount_o
);

   localparam int PTR_WIDTH = $clog2(FIFO_DEPTH);
   localparam int RR_WIDTH  = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;

   // Per-unit FIFO storage (no reset needed: occupancy gates every read)
   logic [REG_ADDR_WIDTH-1:0]  mem_addr [NUM_UNITS][FIFO_DEPTH];
   logic [DATA_WIDTH-1:0]      mem_data [NUM_UNITS][FIFO_DEPTH];
   logic [UNIT_CODE_WIDTH-1:0] mem_code [NUM_UNITS][FIFO_DEPTH];

   logic [PTR_WIDTH-1:0]       wr_ptr [NUM_UNITS];
   logic [PTR_WIDTH-1:0]       rd_ptr [NUM_UNITS];
   logic [CNT_WIDTH-1:0]       count  [NUM_UNITS];

   logic [REG_ADDR_WIDTH-1:0]  head_addr [NUM_UNITS];
   logic [DATA_WIDTH-1:0]      head_data [NUM_UNITS];
   logic [UNIT_CODE_WIDTH-1:0] head_code [NUM_UNITS];

   logic [NUM_UNITS-1:0]       push;
   logic [NUM_UNITS-1:0]       pop;

   logic [RR_WIDTH-1:0]        rr_ptr;
   logic [RR_WIDTH-1:0]        rr_next;

   logic [NUM_WB_PORTS-1:0]    g_en;
   logic [REG_ADDR_WIDTH-1:0]  g_addr [NUM_WB_PORTS];
   logic [DATA_WIDTH-1:0]      g_data [NUM_WB_PORTS];
   logic [UNIT_CODE_WIDTH-1:0] g_code [NUM_WB_PORTS];

   int                         n_grant;
   int                         unit_idx;
   logic                       cand_valid;
   logic                       cand_ok;
   logic [REG_ADDR_WIDTH-1:0]  cand_addr;
   logic [DATA_WIDTH-1:0]      cand_data;
   logic [UNIT_CODE_WIDTH-1:0] cand_code;

   // Ready depends only on registered occupancy, so no path from the pop side
   for (genvar k = 0; k < NUM_UNITS; k++) begin : g_unit
      assign unitReady_o[k]                        = (count[k] != CNT_WIDTH'(FIFO_DEPTH));
      assign push[k]                               = unitValid_i[k] & unitReady_o[k];
      assign head_addr[k]                          = mem_addr[k][rd_ptr[k]];
      assign head_data[k]                          = mem_data[k][rd_ptr[k]];
      assign head_code[k]                          = mem_code[k][rd_ptr[k]];
      assign fifoCount_o[k*CNT_WIDTH +: CNT_WIDTH] = count[k];
   end

   // Round-robin scan from rr_ptr; a head that repeats an already granted addr is deferred
   always_comb begin
      pop        = '0;
      g_en       = '0;
      rr_next    = rr_ptr;
      n_grant    = 0;
      unit_idx   = 0;
      cand_valid = 1'b0;
      cand_ok    = 1'b0;
      cand_addr  = '0;
      cand_data  = '0;
      cand_code  = '0;
      for (int p = 0; p < NUM_WB_PORTS; p++) begin
         g_addr[p] = '0;
         g_data[p] = '0;
         g_code[p] = '0;
      end
      for (int i = 0; i < NUM_UNITS; i++) begin
         unit_idx   = (int'(rr_ptr) + i) % NUM_UNITS;
         cand_valid = 1'b0;
         cand_addr  = '0;
         cand_data  = '0;
         cand_code  = '0;
         for (int k = 0; k < NUM_UNITS; k++) begin
            if (k == unit_idx) begin
               cand_valid = (count[k] != '0);
               cand_addr  = head_addr[k];
               cand_data  = head_data[k];
               cand_code  = head_code[k];
            end
         end
         cand_ok = cand_valid && (n_grant < NUM_WB_PORTS) && !stall_i;
         for (int p = 0; p < NUM_WB_PORTS; p++) begin
            if ((p < n_grant) && (g_addr[p] == cand_addr)) begin
               cand_ok = 1'b0;
            end
         end
         if (cand_ok) begin
            for (int p = 0; p < NUM_WB_PORTS; p++) begin
               if (p == n_grant) begin
                  g_en[p]   = 1'b1;
                  g_addr[p] = cand_addr;
                  g_data[p] = cand_data;
                  g_code[p] = cand_code;
               end
            end
            for (int k = 0; k < NUM_UNITS; k++) begin
               if (k == unit_idx) begin
                  pop[k] = 1'b1;
               end
            end
            rr_next = RR_WIDTH'((unit_idx + 1) % NUM_UNITS);
            n_grant = n_grant + 1;
         end
      end
   end

   // FIFO pointers and occupancy; simultaneous push and pop leave the count unchanged
   always_ff @(posedge clock_i or negedge reset_i) begin
      if (!reset_i) begin
         for (int k = 0; k < NUM_UNITS; k++) begin
            wr_ptr[k] <= '0;
            rd_ptr[k] <= '0;
            count[k]  <= '0;
         end
      end else begin
         for (int k = 0; k < NUM_UNITS; k++) begin
            if (push[k]) begin
               wr_ptr[k] <= wr_ptr[k] + PTR_WIDTH'(1);
            end
            if (pop[k]) begin
               rd_ptr[k] <= rd_ptr[k] + PTR_WIDTH'(1);
            end
            count[k] <= count[k] + CNT_WIDTH'(push[k]) - CNT_WIDTH'(pop[k]);
         end
      end
   end

   // Accepted entries are written at the tail of their unit's FIFO
   always_ff @(posedge clock_i) begin
      for (int k = 0; k < NUM_UNITS; k++) begin
         if (push[k]) begin
            mem_addr[k][wr_ptr[k]] <= unitAddr_i[k*REG_ADDR_WIDTH +: REG_ADDR_WIDTH];
            mem_data[k][wr_ptr[k]] <= unitData_i[k*DATA_WIDTH +: DATA_WIDTH];
            mem_code[k][wr_ptr[k]] <= unitCode_i[k*UNIT_CODE_WIDTH +: UNIT_CODE_WIDTH];
         end
      end
   end

   // Register the grants onto the write ports; stall freezes outputs and the rr pointer
   always_ff @(posedge clock_i or negedge reset_i) begin
      if (!reset_i) begin
         wbEnable_o <= '0;
         wbAddr_o   <= '0;
         wbData_o   <= '0;
         wbCode_o   <= '0;
         rr_ptr     <= '0;
      end else if (!stall_i) begin
         wbEnable_o <= g_en;
         for (int p = 0; p < NUM_WB_PORTS; p++) begin
            wbAddr_o[p*REG_ADDR_WIDTH +: REG_ADDR_WIDTH]    <= g_addr[p];
            wbData_o[p*DATA_WIDTH +: DATA_WIDTH]            <= g_data[p];
            wbCode_o[p*UNIT_CODE_WIDTH +: UNIT_CODE_WIDTH]  <= g_code[p];
         end
         rr_ptr <= rr_next;
      end
   end

endmodule
